enemy_sprite_engine: RTL and testbench

ENEMY_SPRITE_ENGINE -- requirements
Module: enemy_sprite_engine

---
 rtl/enemy_sprite_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_enemy_sprite_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sprite_engine.sv
// -----------------------------------------------------------------------------
// enemy_sprite_engine
//
// Holds N_ENEMY enemy slots (active, x, y). Each frame the active enemies fall
// by `speed` lines. Any enemy that reaches the bottom of the screen is retired,
// and pass_pulse reports the retirement. For every raster position the engine
// finds the lowest-index enemy covering the pixel. It looks up that enemy's
// sprite texel in a shared ROM through a two-stage pipeline.
//
// Optional feature: define ENEMY_COLLISION_EN to add the player ports and a
// sticky player/enemy collision flag.
//
// Ports
//   clk, rst_n             pixel clock, asynchronous active-low reset
//   hcount, vcount         raster position from the VGA timing block
//   speed                  lines per frame added to each active enemy's y
//   spawn_valid/ready/x    spawn handshake; x is the lane of the new enemy
//   rom_addr / rom_data    shared sprite ROM (data valid 1 cycle after addr)
//   pix_valid / pix_data   enemy pixel to the mixer (data 0 when not valid)
//   active                 slot occupancy
//   pass_pulse             one-cycle pulse when enemies leave the screen
//   player_x, player_y     player box origin          (ENEMY_COLLISION_EN)
//   collision              sticky, cleared on frame_tick (ENEMY_COLLISION_EN)
// -----------------------------------------------------------------------------
module enemy_sprite_engine #(
    parameter int N_ENEMY = 4,
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 64,
    parameter int SCR_H   = 480,
    parameter int SCR_W   = 640,
    parameter int ADDR_W  = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          hcount,
    input  logic [9:0]          vcount,
    input  logic [3:0]          speed,
    input  logic                spawn_valid,
    output logic                spawn_ready,
    input  logic [9:0]          spawn_x,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [2:0]          rom_data,
    output logic                pix_valid,
    output logic [2:0]          pix_data,
    output logic [N_ENEMY-1:0]  active,
    output logic                pass_pulse
`ifdef ENEMY_COLLISION_EN
    ,
    input  logic [9:0]          player_x,
    input  logic [9:0]          player_y,
    output logic                collision
`endif
);

    localparam int          SW_LOG = $clog2(SPR_W);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);
    localparam logic [10:0] SCR_H11 = 11'(SCR_H);
    localparam logic [10:0] SCR_W11 = 11'(SCR_W);

    if (SPR_W * SPR_H > (1 << ADDR_W)) begin : g_rom_too_small
        $error("enemy_sprite_engine: SPR_W*SPR_H exceeds the ROM address space");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_ENEMY-1:0] active_q, active_d;
    logic [9:0]         x_q [N_ENEMY];
    logic [9:0]         x_d [N_ENEMY];
    logic [9:0]         y_q [N_ENEMY];
    logic [9:0]         y_d [N_ENEMY];
    logic               pass_pulse_q, pass_pulse_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               hit_q, hit_d;
    logic               pix_valid_q, pix_valid_d;
    logic [2:0]         pix_data_q, pix_data_d;

    // -------------------------------------------------------------------------
    // Raster decode
    // -------------------------------------------------------------------------
    logic [10:0] hc11, vc11;
    logic        frame_tick;
    logic        in_screen;

    assign hc11       = {1'b0, hcount};
    assign vc11       = {1'b0, vcount};
    assign frame_tick = (hcount == 10'd0) && (vc11 == SCR_H11);
    assign in_screen  = (hc11 < SCR_W11) && (vc11 < SCR_H11);

    // -------------------------------------------------------------------------
    // Per-slot hit test, texel address and frame-update arithmetic
    // -------------------------------------------------------------------------
    logic [N_ENEMY-1:0] slot_hit;
    logic [N_ENEMY-1:0] slot_exit;
    logic [ADDR_W-1:0]  slot_addr [N_ENEMY];
    logic [10:0]        y_sum     [N_ENEMY];
`ifdef ENEMY_COLLISION_EN
    logic [N_ENEMY-1:0] slot_ovl;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_ENEMY; gi++) begin : g_slot
            logic [10:0] ex, ey, dx, dy;
            assign ex = {1'b0, x_q[gi]};
            assign ey = {1'b0, y_q[gi]};
            assign dx = hc11 - ex;
            assign dy = vc11 - ey;

            // 11-bit bounds: a sprite near the right/bottom edge never wraps
            // back to column/line 0.
            assign slot_hit[gi] = active_q[gi] && in_screen
                               && (hc11 >= ex) && (hc11 < ex + SPR_W11)
                               && (vc11 >= ey) && (vc11 < ey + SPR_H11);

            // SPR_W is a power of two, so the row stride is a shift.
            assign slot_addr[gi] = (ADDR_W'(dy) << SW_LOG) + ADDR_W'(dx);

            assign y_sum[gi]     = ey + {7'b0, speed};
            assign slot_exit[gi] = active_q[gi] && (y_sum[gi] >= SCR_H11);

`ifdef ENEMY_COLLISION_EN
            logic [10:0] px, py;
            assign px = {1'b0, player_x};
            assign py = {1'b0, player_y};
            // Boxes that only touch along an edge do not collide.
            assign slot_ovl[gi] = active_q[gi]
                               && (ex < px + SPR_W11) && (px < ex + SPR_W11)
                               && (ey < py + SPR_H11) && (py < ey + SPR_H11);
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Spawn: lowest free slot; never accepted on the frame_tick cycle so a
    // spawn and a frame update cannot touch the same slot together.
    // -------------------------------------------------------------------------
    logic [N_ENEMY-1:0] spawn_sel;
    logic               spawn_fire;

    always_comb begin
        logic taken;
        spawn_sel = '0;
        taken     = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (!active_q[i] && !taken) begin
                spawn_sel[i] = 1'b1;
                taken        = 1'b1;
            end
        end
    end

    assign spawn_ready = (~&active_q) && !frame_tick;
    assign spawn_fire  = spawn_valid && spawn_ready;

    // -------------------------------------------------------------------------
    // Slot next state
    // -------------------------------------------------------------------------
    always_comb begin
        active_d     = active_q;
        x_d          = x_q;
        y_d          = y_q;
        pass_pulse_d = frame_tick && (|slot_exit);
        for (int i = 0; i < N_ENEMY; i++) begin
            if (frame_tick && active_q[i]) begin
                if (slot_exit[i]) begin
                    active_d[i] = 1'b0;
                    y_d[i]      = 10'd0;
                end else begin
                    y_d[i] = y_sum[i][9:0];
                end
            end else if (spawn_fire && spawn_sel[i]) begin
                active_d[i] = 1'b1;
                x_d[i]      = spawn_x;
                y_d[i]      = 10'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pixel pipeline. Stage 1 registers the winner's texel address; the ROM
    // answers combinationally within the next cycle; stage 2 registers the
    // pixel. Scanning downward leaves the lowest-index hit as the winner.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [ADDR_W-1:0] win_addr;
        win_addr = rom_addr_q;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                win_addr = slot_addr[i];
            end
        end
        hit_d       = |slot_hit;
        rom_addr_d  = win_addr;
        pix_valid_d = hit_q && (rom_data != 3'b000);
        pix_data_d  = pix_valid_d ? rom_data : 3'b000;
    end

`ifdef ENEMY_COLLISION_EN
    logic collision_q, collision_d;

    // A set in the same cycle as frame_tick wins over the clear.
    always_comb begin
        collision_d = collision_q;
        if (|slot_ovl) begin
            collision_d = 1'b1;
        end else if (frame_tick) begin
            collision_d = 1'b0;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= '0;
            pass_pulse_q <= 1'b0;
            rom_addr_q   <= '0;
            hit_q        <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 3'b000;
            for (int i = 0; i < N_ENEMY; i++) begin
                x_q[i] <= 10'd0;
                y_q[i] <= 10'd0;
            end
        end else begin
            active_q     <= active_d;
            pass_pulse_q <= pass_pulse_d;
            rom_addr_q   <= rom_addr_d;
            hit_q        <= hit_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            for (int i = 0; i < N_ENEMY; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

`ifdef ENEMY_COLLISION_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`endif

    assign active     = active_q;
    assign pass_pulse = pass_pulse_q;
    assign rom_addr   = rom_addr_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_enemy_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_enemy_sprite_engine
//
// Directed bench for enemy_sprite_engine. The sprite ROM is modelled
// combinationally as rom_data = rom_addr[2:0]. This makes each expected texel
// value easy to derive by hand, and it makes every address that is a multiple
// of 8 transparent. Pixel lookups come from a table of records; falling,
// exits, spawn back-pressure, reset and collision are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_enemy_sprite_engine;

    localparam int N_ENEMY = 4;
    localparam int ADDR_W  = 11;

    logic               clk;
    logic               rst_n;
    logic [9:0]         hcount, vcount;
    logic [3:0]         speed;
    logic               spawn_valid;
    logic               spawn_ready;
    logic [9:0]         spawn_x;
    logic [ADDR_W-1:0]  rom_addr;
    logic [2:0]         rom_data;
    logic               pix_valid;
    logic [2:0]         pix_data;
    logic [N_ENEMY-1:0] active;
    logic               pass_pulse;
`ifdef ENEMY_COLLISION_EN
    logic [9:0]         player_x, player_y;
    logic               collision;
`endif

    int checks = 0;
    int errors = 0;

    enemy_sprite_engine #(
        .N_ENEMY(N_ENEMY), .SPR_W(32), .SPR_H(64),
        .SCR_H(480), .SCR_W(640), .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .speed       (speed),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_x     (spawn_x),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .active      (active),
        .pass_pulse  (pass_pulse)
`ifdef ENEMY_COLLISION_EN
        ,
        .player_x    (player_x),
        .player_y    (player_y),
        .collision   (collision)
`endif
    );

    assign rom_data = rom_addr[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic [10:0] exp_addr;
        logic        exp_pv;
        logic [2:0]  exp_pd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end else begin
            $display("ok   %s[%0d]: %0d", nm, idx, act);
        end
    endtask

    task automatic idle_raster();
        hcount = 10'd700;
        vcount = 10'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one raster position for a cycle, then idle; checks the address
    // after stage 1 and the pixel one cycle later.
    task automatic apply_vec(input vec_t v, input int idx);
        hcount = v.hc;
        vcount = v.vc;
        cycle();
        chk("addr_s1", idx, 32'(rom_addr), 32'(v.exp_addr));
        chk("pv_latency", idx, 32'(pix_valid), 32'd0);
        idle_raster();
        cycle();
        chk("pix_valid", idx, 32'(pix_valid), 32'(v.exp_pv));
        chk("pix_data", idx, 32'(pix_data), 32'(v.exp_pd));
        chk("addr_hold", idx, 32'(rom_addr), 32'(v.exp_addr));
    endtask

    task automatic spawn(input logic [9:0] x);
        spawn_x     = x;
        spawn_valid = 1'b1;
        cycle();
        spawn_valid = 1'b0;
    endtask

    // One frame_tick cycle, then count pass_pulse over it and three idle cycles.
    task automatic tick_frame(input logic [3:0] spd, output int pulses);
        hcount = 10'd0;
        vcount = 10'd480;
        speed  = spd;
        cycle();
        pulses = int'(pass_pulse);
        idle_raster();
        for (int k = 0; k < 3; k++) begin
            cycle();
            pulses += int'(pass_pulse);
        end
    endtask

    task automatic ticks(input int n, input logic [3:0] spd);
        int p;
        for (int k = 0; k < n; k++) tick_frame(spd, p);
    endtask

    initial begin
        int p;
        vec_t v;

        tbl[0]  = '{10'd110, 10'd5,  11'd170,  1'b1, 3'd2};
        tbl[1]  = '{10'd100, 10'd0,  11'd0,    1'b0, 3'd0};
        tbl[2]  = '{10'd131, 10'd63, 11'd2047, 1'b1, 3'd7};
        tbl[3]  = '{10'd142, 10'd5,  11'd2047, 1'b0, 3'd0};
        tbl[4]  = '{10'd99,  10'd5,  11'd2047, 1'b0, 3'd0};
        tbl[5]  = '{10'd105, 10'd64, 11'd2047, 1'b0, 3'd0};
        tbl[6]  = '{10'd115, 10'd2,  11'd79,   1'b1, 3'd7};
        tbl[7]  = '{10'd116, 10'd2,  11'd80,   1'b0, 3'd0};
        tbl[8]  = '{10'd140, 10'd10, 11'd350,  1'b1, 3'd6};
        tbl[9]  = '{10'd310, 10'd5,  11'd170,  1'b1, 3'd2};
        tbl[10] = '{10'd329, 10'd1,  11'd61,   1'b1, 3'd5};
        tbl[11] = '{10'd332, 10'd1,  11'd61,   1'b0, 3'd0};

        rst_n       = 1'b0;
        speed       = 4'd0;
        spawn_valid = 1'b0;
        spawn_x     = 10'd0;
`ifdef ENEMY_COLLISION_EN
        player_x    = 10'd100;
        player_y    = 10'd100;
`endif
        idle_raster();
        repeat (3) cycle();

        // Reset state
        chk("rst_active", 0, 32'(active), 32'd0);
        chk("rst_rom_addr", 0, 32'(rom_addr), 32'd0);
        chk("rst_pix_valid", 0, 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 0, 32'(pix_data), 32'd0);
        chk("rst_pass", 0, 32'(pass_pulse), 32'd0);
`ifdef ENEMY_COLLISION_EN
        chk("rst_collision", 0, 32'(collision), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Spawn three enemies: slot0 x=100, slot1 x=300, slot2 x=110, all y=0
        chk("ready_empty", 0, 32'(spawn_ready), 32'd1);
        spawn(10'd100);
        chk("active_spawn", 0, 32'(active), 32'b0001);
        spawn(10'd300);
        spawn(10'd110);
        chk("active_spawn", 1, 32'(active), 32'b0111);

        // spawn_ready drops during frame_tick (no clock edge taken here)
        hcount = 10'd0;
        vcount = 10'd480;
        #1;
        chk("ready_tick", 0, 32'(spawn_ready), 32'd0);
        idle_raster();
        #1;
        chk("ready_tick", 1, 32'(spawn_ready), 32'd1);
        cycle();

        // Pixel lookup table (priority, transparency, edges, address hold)
        for (int i = 0; i < 12; i++) apply_vec(tbl[i], i);

        // Move slots 0..2 down to y=470
        ticks(31, 4'd15);
        tick_frame(4'd5, p);
        chk("pulses_470", 0, 32'(p), 32'd0);
        chk("active_470", 0, 32'(active), 32'b0111);

        // Fill the last slot at the right edge, then try a rejected spawn
        spawn(10'd620);
        chk("active_full", 0, 32'(active), 32'b1111);
        chk("ready_full", 0, 32'(spawn_ready), 32'd0);
        spawn(10'd50);
        chk("active_reject", 0, 32'(active), 32'b1111);

        v = '{10'd639, 10'd0,   11'd19,  1'b1, 3'd3}; apply_vec(v, 100);
        v = '{10'd640, 10'd0,   11'd19,  1'b0, 3'd0}; apply_vec(v, 101);
        v = '{10'd103, 10'd475, 11'd163, 1'b1, 3'd3}; apply_vec(v, 102);
        v = '{10'd103, 10'd2,   11'd163, 1'b0, 3'd0}; apply_vec(v, 103);

        // Three slots exit together -> one pulse; slot3 moves to y=10
        tick_frame(4'd10, p);
        chk("pulses_multi", 0, 32'(p), 32'd1);
        chk("active_multi", 0, 32'(active), 32'b1000);

        // Freed lowest slot takes the next spawn
        spawn(10'd200);
        chk("active_refill", 0, 32'(active), 32'b1001);

        // slot3: 10 -> 475 -> 479 (stays); slot0: 0 -> 465 -> 469
        ticks(31, 4'd15);
        tick_frame(4'd4, p);
        chk("pulses_479", 0, 32'(p), 32'd0);
        chk("active_479", 0, 32'(active), 32'b1001);
        v = '{10'd625, 10'd479, 11'd5, 1'b1, 3'd5}; apply_vec(v, 104);

        // slot3 exits alone; slot0 -> 470
        tick_frame(4'd1, p);
        chk("pulses_single", 0, 32'(p), 32'd1);
        chk("active_single", 0, 32'(active), 32'b0001);
        v = '{10'd203, 10'd475, 11'd163, 1'b1, 3'd3}; apply_vec(v, 105);

        // y=470, speed=10 -> exit
        tick_frame(4'd10, p);
        chk("pulses_470_10", 0, 32'(p), 32'd1);
        chk("active_470_10", 0, 32'(active), 32'b0000);

        // Reset mid-line with a pending spawn
        spawn(10'd100);
        hcount = 10'd110;
        vcount = 10'd5;
        repeat (2) cycle();
        chk("pre_rst_pv", 0, 32'(pix_valid), 32'd1);
        spawn_x     = 10'd40;
        spawn_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_active", 0, 32'(active), 32'd0);
        chk("midrst_rom_addr", 0, 32'(rom_addr), 32'd0);
        chk("midrst_pix_valid", 0, 32'(pix_valid), 32'd0);
        chk("midrst_pix_data", 0, 32'(pix_data), 32'd0);
        chk("midrst_pass", 0, 32'(pass_pulse), 32'd0);
        repeat (2) @(posedge clk);
        spawn_valid = 1'b0;
        idle_raster();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("postrst_active", 0, 32'(active), 32'd0);
        chk("postrst_pix_valid", 0, 32'(pix_valid), 32'd0);

`ifdef ENEMY_COLLISION_EN
        // Player at (100,100); enemy at x=120 falls to y=130
        player_x = 10'd100;
        player_y = 10'd100;
        spawn(10'd120);
        cycle();
        chk("coll_y0", 0, 32'(collision), 32'd0);
        ticks(10, 4'd13);
        chk("coll_120_130", 0, 32'(collision), 32'd1);
        player_y = 10'd300;
        repeat (2) cycle();
        chk("coll_sticky", 0, 32'(collision), 32'd1);
        tick_frame(4'd0, p);
        chk("coll_cleared", 0, 32'(collision), 32'd0);
        // Edge-touching boxes do not collide; one pixel of overlap does
        player_y = 10'd0;
        spawn(10'd132);
        repeat (2) cycle();
        chk("coll_touch", 0, 32'(collision), 32'd0);
        player_x = 10'd101;
        cycle();
        chk("coll_overlap", 0, 32'(collision), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
